// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage.
package riscv_pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ILEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer holding a response that Decode could not accept yet.
module fetch_skid_buf
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [AW-1:0]   i_pc,
  input  logic [ILEN-1:0] i_instr,
  output logic            o_valid,
  output logic [AW-1:0]   o_pc,
  output logic [ILEN-1:0] o_instr
);

  logic            r_valid;
  logic [AW-1:0]   r_pc;
  logic [ILEN-1:0] r_instr;

  // Capture on load, invalidate on clear; load wins if both are seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// IF stage and IF/ID register: one-outstanding instruction fetch with redirect
// handling and stale-response dropping.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             PC_src_D,
  input  logic [XLEN-1:0]  pc_target_D,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [ILEN-1:0]  imem_rdata,
  output logic             imem_stall,
  output logic [XLEN-1:0]  pc_D,
  output logic [XLEN-1:0]  pc_plus4_D,
  output logic [ILEN-1:0]  instr_D,
  output logic             valid_D,
  output logic [CNT_W-1:0] perf_fetch,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_redirect
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc_F;
  logic            r_run;
  ifid_t           r_ifid;
  logic [XLEN-1:0] r_pc_plus4_D;

  logic            w_redir;
  logic            w_adv;
  logic            w_req;
  logic            w_ld_mem;
  logic            w_ld_skid;
  logic            w_skid_load;
  logic            w_skid_clear;
  logic            w_skid_valid;
  logic [XLEN-1:0] w_skid_pc;
  logic [ILEN-1:0] w_skid_instr;
  logic [XLEN-1:0] w_pc_plus4_F;

  // A redirect is only accepted when fetch is not stalled; the branch re-resolves later.
  assign w_redir      = PC_src_D & ~stall_F;
  assign w_adv        = ~stall_F & ~stall_D & ~flush_D;
  // r_run keeps the request low while in reset and for the release cycle.
  assign w_req        = r_run & (r_state == FETCH) & ~stall_F & ~stall_D & ~w_redir;
  assign w_ld_mem     = (r_state == WAIT) & imem_rvalid & ~w_redir & w_adv;
  assign w_ld_skid    = (r_state == HOLD) & w_skid_valid & ~w_redir & w_adv;
  assign w_skid_load  = (r_state == WAIT) & imem_rvalid & ~w_redir & ~w_adv;
  assign w_skid_clear = (r_state == HOLD) & (w_redir | w_adv);
  assign w_pc_plus4_F = r_pc_F + XLEN'(4);

  assign imem_req   = w_req;
  assign imem_addr  = r_pc_F;
  assign imem_stall = (r_state == WAIT) & ~imem_rvalid;

  fetch_skid_buf #(
    .AW (XLEN)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_pc_F),
    .i_instr (imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  // Fetch FSM and pc_F update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc_F  <= RESET_PC;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        FETCH: begin
          if (w_redir) begin
            r_pc_F <= pc_target_D;
          end else if (w_req) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_redir) begin
            r_pc_F  <= pc_target_D;
            r_state <= imem_rvalid ? FETCH : DROP;
          end else if (imem_rvalid) begin
            if (w_adv) begin
              r_pc_F  <= w_pc_plus4_F;
              r_state <= FETCH;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (w_redir) begin
            r_pc_F  <= pc_target_D;
            r_state <= FETCH;
          end else if (w_adv) begin
            r_pc_F  <= w_pc_plus4_F;
            r_state <= FETCH;
          end
        end
        DROP: begin
          if (w_redir) begin
            r_pc_F <= pc_target_D;
          end
          if (imem_rvalid) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // IF/ID register: flush beats stall beats load; anything else is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid       <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      r_pc_plus4_D <= XLEN'(4);
    end else if (flush_D) begin
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end else if (stall_D) begin
      r_ifid       <= r_ifid;
    end else if (w_ld_mem) begin
      r_ifid       <= '{pc: r_pc_F, instr: imem_rdata, valid: 1'b1};
      r_pc_plus4_D <= w_pc_plus4_F;
    end else if (w_ld_skid) begin
      r_ifid       <= '{pc: w_skid_pc, instr: w_skid_instr, valid: 1'b1};
      r_pc_plus4_D <= w_skid_pc + XLEN'(4);
    end else begin
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end
  end

  assign pc_D       = r_ifid.pc;
  assign instr_D    = r_ifid.instr;
  assign valid_D    = r_ifid.valid;
  assign pc_plus4_D = r_pc_plus4_D;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_fetch;
  logic [CNT_W-1:0] r_perf_bubble;
  logic [CNT_W-1:0] r_perf_redirect;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch    <= '0;
      r_perf_bubble   <= '0;
      r_perf_redirect <= '0;
    end else begin
      if (w_ld_mem | w_ld_skid) r_perf_fetch    <= r_perf_fetch + CNT_W'(1);
      if (!r_ifid.valid)        r_perf_bubble   <= r_perf_bubble + CNT_W'(1);
      if (w_redir)              r_perf_redirect <= r_perf_redirect + CNT_W'(1);
    end
  end

  assign perf_fetch    = r_perf_fetch;
  assign perf_bubble   = r_perf_bubble;
  assign perf_redirect = r_perf_redirect;
`else
  assign perf_fetch    = '0;
  assign perf_bubble   = '0;
  assign perf_redirect = '0;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed testbench for fetch_stage_ctrl: per-cycle vector table for the
// basic fetch/redirect flow, hand sequences for latency, DROP, HOLD, stall_F
// vs redirect, flush under stall and reset during a request.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_F, stall_D, flush_D, PC_src_D;
  logic [31:0] pc_target_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_stall;
  logic [31:0] pc_D, pc_plus4_D, instr_D;
  logic        valid_D;
  logic [31:0] perf_fetch, perf_bubble, perf_redirect;

  fetch_stage_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_F       (stall_F),
    .stall_D       (stall_D),
    .flush_D       (flush_D),
    .PC_src_D      (PC_src_D),
    .pc_target_D   (pc_target_D),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .imem_stall    (imem_stall),
    .pc_D          (pc_D),
    .pc_plus4_D    (pc_plus4_D),
    .instr_D       (instr_D),
    .valid_D       (valid_D),
    .perf_fetch    (perf_fetch),
    .perf_bubble   (perf_bubble),
    .perf_redirect (perf_redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  typedef struct {
    logic        sf, sd, fl, ps;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        stl;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tv [12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  function automatic vec_t mk(input logic ps, input logic [31:0] tgt, input logic req,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.sf = 1'b0; v.sd = 1'b0; v.fl = 1'b0; v.ps = ps; v.tgt = tgt;
    v.req = req; v.addr = addr; v.stl = 1'b0; v.vld = vld; v.pc = pc; v.ins = ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample the request, then drive the memory response for the new cycle.
  task automatic cycle();
    logic        rs;
    logic [31:0] ra;
    #1;
    rs = imem_req;
    ra = imem_addr;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (rs && rst_n) begin
      mem_cnt  = mem_lat;
      mem_addr = ra;
    end
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
  endtask

  task automatic wait_req(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (imem_req) found = 1'b1;
      else cycle();
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (valid_D) found = 1'b1;
      else cycle();
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic clr_in();
    stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0; PC_src_D = 1'b0; pc_target_D = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    int          scnt, rcnt;
    logic [31:0] sv_pc, sv_ins, sv_vld, pr0, pb0;

    // Per-cycle vectors starting at the cycle reset is released (1-cycle memory).
    tv[0]  = mk(0, 0,     0, 32'h00, 0, 32'h00, NOP);
    tv[1]  = mk(0, 0,     1, 32'h00, 0, 32'h00, NOP);
    tv[2]  = mk(0, 0,     0, 32'h00, 0, 32'h00, NOP);
    tv[3]  = mk(0, 0,     1, 32'h04, 1, 32'h00, mem_word(32'h00));
    tv[4]  = mk(0, 0,     0, 32'h04, 0, 32'h00, NOP);
    tv[5]  = mk(0, 0,     1, 32'h08, 1, 32'h04, mem_word(32'h04));
    tv[6]  = mk(0, 0,     0, 32'h08, 0, 32'h04, NOP);
    tv[7]  = mk(0, 0,     1, 32'h0C, 1, 32'h08, mem_word(32'h08));
    tv[8]  = mk(1, 32'h40, 0, 32'h0C, 0, 32'h08, NOP);
    tv[9]  = mk(0, 0,     1, 32'h40, 0, 32'h08, NOP);
    tv[10] = mk(0, 0,     0, 32'h40, 0, 32'h08, NOP);
    tv[11] = mk(0, 0,     1, 32'h44, 1, 32'h40, mem_word(32'h40));

    clr_in();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    rst_n       = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_req",      32'(imem_req),   32'd0);
    chk("rst_addr",     imem_addr,       32'h0);
    chk("rst_stall",    32'(imem_stall), 32'd0);
    chk("rst_valid",    32'(valid_D),    32'd0);
    chk("rst_pc_D",     pc_D,            32'h0);
    chk("rst_pc4_D",    pc_plus4_D,      32'h4);
    chk("rst_instr",    instr_D,         NOP);
    chk("rst_perf_f",   perf_fetch,      32'h0);
    chk("rst_perf_b",   perf_bubble,     32'h0);
    chk("rst_perf_r",   perf_redirect,   32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Table: sequential fetch then redirect in WAIT with same-cycle response
    for (int i = 0; i < 12; i++) begin
      stall_F = tv[i].sf; stall_D = tv[i].sd; flush_D = tv[i].fl;
      PC_src_D = tv[i].ps; pc_target_D = tv[i].tgt;
      #1;
      chk($sformatf("v%0d_req", i),   32'(imem_req),   32'(tv[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr,       tv[i].addr);
      chk($sformatf("v%0d_stall", i), 32'(imem_stall), 32'(tv[i].stl));
      chk($sformatf("v%0d_valid", i), 32'(valid_D),    32'(tv[i].vld));
      chk($sformatf("v%0d_pc_D", i),  pc_D,            tv[i].pc);
      chk($sformatf("v%0d_pc4_D", i), pc_plus4_D,      tv[i].pc + 32'd4);
      chk($sformatf("v%0d_instr", i), instr_D,         tv[i].ins);
      cycle();
    end
    clr_in();

    // 3-cycle memory: two stall cycles, one request per address
    mem_lat = 3;
    wait_req("lat3_req_timeout");
    chk("lat3_addr", imem_addr, 32'h48);
    cycle();
    scnt = 0;
    rcnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (imem_stall) scnt++;
      if (imem_req)   rcnt++;
      cycle();
    end
    #1;
    chk("lat3_stall_cycles", 32'(scnt), 32'd2);
    chk("lat3_extra_reqs",   32'(rcnt), 32'd0);
    chk("lat3_valid",        32'(valid_D), 32'd1);
    chk("lat3_pc_D",         pc_D, 32'h48);
    chk("lat3_instr",        instr_D, mem_word(32'h48));
    chk("lat3_pc4_D",        pc_plus4_D, 32'h4C);

    // Redirect while waiting without response: DROP the stale response
    pr0 = perf_redirect;
    pb0 = perf_bubble;
    chk("drop_req0",  32'(imem_req), 32'd1);
    chk("drop_addr0", imem_addr, 32'h4C);
    cycle();
    PC_src_D = 1'b1; pc_target_D = 32'h100;
    #1;
    chk("drop_stall_wait", 32'(imem_stall), 32'd1);
    cycle();
    clr_in();
    #1;
    chk("drop_addr_tgt", imem_addr, 32'h100);
    chk("drop_req_in_drop", 32'(imem_req), 32'd0);
    chk("drop_bubble", 32'(valid_D), 32'd0);
    cycle();
    #1;
    chk("drop_stale_rvalid_seen", 32'(imem_rvalid), 32'd1);
    chk("drop_req_stale_cycle", 32'(imem_req), 32'd0);
    cycle();
    #1;
    chk("drop_stale_discarded", 32'(valid_D), 32'd0);
    chk("drop_refetch_req",  32'(imem_req), 32'd1);
    chk("drop_refetch_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redirect_delta", perf_redirect - pr0, 32'd1);
    chk("perf_bubble_grew", 32'(perf_bubble - pb0 >= 32'd1), 32'd1);
`else
    chk("perf_off_redirect", perf_redirect ^ pr0, 32'h0);
    chk("perf_off_fetch", perf_fetch, 32'h0);
    chk("perf_off_bubble", perf_bubble ^ pb0, 32'h0);
`endif
    wait_valid("drop_valid_timeout");
    chk("drop_new_pc",    pc_D, 32'h100);
    chk("drop_new_instr", instr_D, mem_word(32'h100));

    // stall_D for 3 cycles when the response lands: HOLD then release
    mem_lat = 1;
    cycle();
    stall_D = 1'b1;
    #1;
    chk("hold_rvalid", 32'(imem_rvalid), 32'd1);
    sv_pc = pc_D; sv_ins = instr_D; sv_vld = 32'(valid_D);
    cycle();
    #1;
    chk("hold1_req",   32'(imem_req), 32'd0);
    chk("hold1_valid", 32'(valid_D), sv_vld);
    chk("hold1_pc_D",  pc_D, sv_pc);
    chk("hold1_instr", instr_D, sv_ins);
    chk("hold1_stall", 32'(imem_stall), 32'd0);
    cycle();
    #1;
    chk("hold2_req",   32'(imem_req), 32'd0);
    chk("hold2_instr", instr_D, sv_ins);
    cycle();
    stall_D = 1'b0;
    #1;
    chk("hold3_valid", 32'(valid_D), sv_vld);
    chk("hold3_addr",  imem_addr, 32'h104);
    cycle();
    #1;
    chk("hold_out_valid", 32'(valid_D), 32'd1);
    chk("hold_out_pc",    pc_D, 32'h104);
    chk("hold_out_instr", instr_D, mem_word(32'h104));
    chk("hold_out_addr",  imem_addr, 32'h108);
    chk("hold_out_req",   32'(imem_req), 32'd1);

    // stall_F with redirect: redirect ignored, then taken alone
    stall_F = 1'b1; PC_src_D = 1'b1; pc_target_D = 32'h200;
    #1;
    chk("sfr_req", 32'(imem_req), 32'd0);
    cycle();
    #1;
    chk("sfr_pc_hold", imem_addr, 32'h108);
    stall_F = 1'b0;
    #1;
    chk("sfr_req_redir", 32'(imem_req), 32'd0);
    cycle();
    clr_in();
    #1;
    chk("sfr_addr_tgt", imem_addr, 32'h200);
    chk("sfr_req_tgt",  32'(imem_req), 32'd1);
    wait_valid("sfr_valid_timeout");
    chk("sfr_pc_D",  pc_D, 32'h200);
    chk("sfr_instr", instr_D, mem_word(32'h200));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redirect_total", perf_redirect, 32'd3);
`endif

    // flush_D wins over stall_D
    stall_D = 1'b1; flush_D = 1'b1;
    cycle();
    clr_in();
    #1;
    chk("flush_valid", 32'(valid_D), 32'd0);
    chk("flush_instr", instr_D, NOP);

    // Reset in the middle of a request
    mem_lat = 3;
    wait_req("mrst_req_timeout");
    cycle();
    rst_n = 1'b0;
    mem_cnt = 0;
    imem_rvalid = 1'b0;
    #1;
    chk("mrst_addr",  imem_addr, 32'h0);
    chk("mrst_req",   32'(imem_req), 32'd0);
    chk("mrst_stall", 32'(imem_stall), 32'd0);
    chk("mrst_valid", 32'(valid_D), 32'd0);
    chk("mrst_pc4",   pc_plus4_D, 32'h4);
    chk("mrst_perf_r", perf_redirect, 32'h0);
    cycle();
    rst_n = 1'b1;
    mem_lat = 1;
    wait_req("mrst_req2_timeout");
    chk("mrst_first_addr", imem_addr, 32'h0);
    cycle();
    wait_valid("mrst_valid_timeout");
    chk("mrst_first_pc",    pc_D, 32'h0);
    chk("mrst_first_instr", instr_D, mem_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
